// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin owner arbiter for one physical SPI bus shared by PORTS masters.
// Ports:
//   clk         system clock
//   rst_L       asynchronous active-low reset
//   req         per-master level request, held for the whole transaction
//   ss_L_ports  per-master chip selects (active low), same wires as the crossbar
//   gnt         one-hot grant, at most one bit set
//   select      one-hot crossbar select, all-zero when no port is on the bus
//   owner       binary index of current or last owner (upper bit 0 when PORTS=2)
//   busy        high while in GRANT or GUARD
//   timeout     one-cycle pulse on forced revoke (0 unless SPI_BUS_ARBITER_TIMEOUT_EN)
// Optional feature macro: SPI_BUS_ARBITER_TIMEOUT_EN enables the grant-length limit
// (TIMEOUT_CYCLES) and per-port lockout until the offending master drops req.
module spi_bus_arbiter #(
  parameter int PORTS          = 3,
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic [PORTS-1:0] req,
  input  logic [PORTS-1:0] ss_L_ports,
  output logic [PORTS-1:0] gnt,
  output logic [PORTS-1:0] select,
  output logic [1:0]       owner,
  output logic             busy,
  output logic             timeout
);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;
  state_t           state;
  logic [GW-1:0]    gcnt;
  logic [PORTS-1:0] elig;
  logic [PORTS-1:0] rot;
  logic [1:0]       pos;
  logic [2:0]       sum;
  logic [1:0]       win;
  logic             revoke;
  logic             leave;
  // Rotate eligible requests so bit 0 is the port right after the last owner;
  // the lowest set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    rot = PORTS'({elig, elig} >> (owner + 2'd1));
    pos = 2'd0;
    for (int j = PORTS - 1; j >= 0; j--)
      if (rot[j]) pos = 2'(j);
    sum = {1'b0, owner} + 3'd1 + {1'b0, pos};
    win = sum >= 3'(PORTS) ? 2'(sum - 3'(PORTS)) : sum[1:0];
  end
  // select is one-hot on the owner in GRANT, so masking with it picks the owner's bits.
  assign leave = state == GRANT && (revoke || (!(|(req & select)) && (|(ss_L_ports & select))));
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
  logic [16:0]      tcnt;
  logic [PORTS-1:0] locked;
  assign revoke = state == GRANT && tcnt == 17'(TIMEOUT_CYCLES - 1);
  assign elig   = req & ~locked;
  // tcnt idles at zero outside GRANT, so it is already clear on GRANT entry.
  always_ff @(posedge clk or negedge rst_L)
    if (!rst_L) begin
      tcnt    <= '0;
      locked  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= revoke;
      tcnt    <= state == GRANT ? tcnt + 17'd1 : '0;
      locked  <= (locked & req) | (revoke ? select : '0);
    end
`else
  assign revoke  = 1'b0;
  assign elig    = req;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_L)
    if (!rst_L) begin
      state  <= IDLE;
      gnt    <= '0;
      select <= '0;
      owner  <= 2'(PORTS - 1);
      busy   <= 1'b0;
      gcnt   <= '0;
    end else begin
      case (state)
        IDLE:
          if (|elig) begin
            owner  <= win;
            gnt    <= PORTS'(1) << win;
            select <= PORTS'(1) << win;
            busy   <= 1'b1;
            state  <= GRANT;
          end
        GRANT:
          if (leave) begin
            gnt   <= '0;
            gcnt  <= GW'(GUARD_CYCLES - 1);
            state <= GUARD;
          end
        GUARD:
          if (gcnt == '0) begin
            select <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            gcnt <= gcnt - GW'(1);
          end
        default: state <= IDLE;
      endcase
    end
endmodule
